alu_issue_ctrl: RTL
===================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, wait cycles before a multiply (op3[3:0]=4'ha/4'hb) is presented to the ALU; legal range 1..15.
REQ-002 SHALL have parameter DIV_LAT, default 8, wait cycles before a divide (op3[3:0]=4'he/4'hf) is presented; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 dec_valid  input  1  decode offers an op.
REQ-006 dec_ready  output  1  controller accepts the op this cycle.
REQ-007 dec_opcode  input  2; dec_op3  input  6; dec_oprd2, dec_oprd3  input  32 each; dec_next_rip  input  64: op fields.
REQ-008 alu_enable  output  1  ALU enable.
REQ-009 alu_opcode 2, alu_op3 6, alu_oprd2 32, alu_oprd3 32, alu_next_rip 64  outputs  held op fields to ALU.
REQ-010 mem_blocked  input  1  memory stage stalled; ALU holds its output.
REQ-011 branch  input  1  ALU resolved a taken/redirect branch; flush.
REQ-012 busy  output  1  an op is held (state != IDLE).
REQ-013 div_fault  output  1  one-cycle pulse: divide by zero discarded.

Function
REQ-014 SHALL implement states IDLE (no op held), WAIT (multi-cycle countdown), EXEC (op presented to ALU).
REQ-015 Op is multi-cycle iff dec_opcode=2 and dec_op3[5:4]!=2'b11 and dec_op3[3:0] in {a,b,e,f}; all others single-cycle.
REQ-016 dec_ready SHALL be combinational: 1 iff reset_n=1, branch=0, and (state=IDLE or (state=EXEC and mem_blocked=0)).
REQ-017 On accept (dec_valid and dec_ready): latch all dec_* fields into the held register; single-cycle -> EXEC; multi-cycle -> WAIT, 4-bit counter loaded with LAT-1.
REQ-018 WAIT: counter decrements every cycle regardless of mem_blocked; counter=0 -> EXEC next cycle; multi-cycle op therefore in WAIT exactly LAT cycles.
REQ-019 alu_enable SHALL be 1 iff state=EXEC; alu_* fields SHALL equal the held register at all times and change only on accept.
REQ-020 EXEC with mem_blocked=1: stay EXEC, alu_enable stays 1, held fields stable.
REQ-021 EXEC with mem_blocked=0: op consumed; if accept same cycle -> back-to-back (EXEC or WAIT per new op), else -> IDLE; sustained single-cycle throughput one op per cycle.
REQ-022 branch=1 in any state: held op discarded, next state IDLE, counter cleared, no accept that cycle; flush outranks accept, countdown and mem_blocked.
REQ-023 dec_valid=1 in WAIT or blocked EXEC: not accepted; decode must hold fields stable.
REQ-024 busy = (state != IDLE), combinational.

Reset
REQ-025 reset_n=0 at posedge: state IDLE, counter 0, held register 0, div_fault 0; alu_enable, busy, dec_ready SHALL read 0 while reset_n=0.
REQ-026 Reset mid-WAIT or mid-EXEC SHALL discard the op with no alu_enable pulse after release; first accept possible in the first cycle with reset_n=1.

Configuration
REQ-027 Macro ALU_DIV_CHECK_EN defined: accepted divide with dec_oprd3=0 SHALL not enter WAIT; state -> IDLE, div_fault=1 for exactly the next cycle, op never reaches ALU.
REQ-028 ALU_DIV_CHECK_EN undefined: divide by zero treated as any divide; div_fault tied 0.

Verification
REQ-029 Reset release, dec_valid=1 add (op3=6'h00, 5+7) every cycle, mem_blocked=0 -> alu_enable high every cycle from 1 cycle after first accept, dec_ready constantly 1.
REQ-030 Multiply (op3=6'h0a) accepted at cycle 0, MUL_LAT=3 -> WAIT cycles 1-3, alu_enable=1 in cycle 4 only, dec_ready=0 cycles 1-3.
REQ-031 Add in EXEC with mem_blocked=1 for 4 cycles -> alu_enable and alu_oprd2/3 stable 4 cycles, dec_ready=0, released next cycle.
REQ-032 branch=1 during WAIT of a divide (DIV_LAT=8, count 5) -> IDLE next cycle, no alu_enable for that divide, dec_ready=0 in flush cycle then 1.
REQ-033 With ALU_DIV_CHECK_EN, divide 100/0 accepted -> div_fault=1 one cycle, alu_enable never 1; without macro -> alu_enable after 8 WAIT cycles, div_fault=0.
REQ-034 reset_n=0 asserted in second WAIT cycle of a multiply -> alu_enable=0, busy=0 after release; next add accepted in first released cycle.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: holds one decoded op and presents it to the ALU.
// Single-cycle ops go straight to EXEC. Multiply and divide ops count down
// MUL_LAT/DIV_LAT cycles in WAIT first. A branch flushes the held op.
// Optional feature macro: ALU_DIV_CHECK_EN. When defined, a divide by zero
// is dropped at accept and div_fault pulses for one cycle.
module alu_issue_ctrl #(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [1:0]  dec_opcode,
    input  logic [5:0]  dec_op3,
    input  logic [31:0] dec_oprd2,
    input  logic [31:0] dec_oprd3,
    input  logic [63:0] dec_next_rip,
    output logic        alu_enable,
    output logic [1:0]  alu_opcode,
    output logic [5:0]  alu_op3,
    output logic [31:0] alu_oprd2,
    output logic [31:0] alu_oprd3,
    output logic [63:0] alu_next_rip,
    input  logic        mem_blocked,
    input  logic        branch,
    output logic        busy,
    output logic        div_fault
);

`ifdef ALU_DIV_CHECK_EN
    localparam bit DIV_CHECK = 1'b1;
`else
    localparam bit DIV_CHECK = 1'b0;
`endif

    localparam logic [3:0] MUL_LD = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_LD = 4'(DIV_LAT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, EXEC} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        div_fault_q;
    logic [1:0]  opcode_q;
    logic [5:0]  op3_q;
    logic [31:0] oprd2_q;
    logic [31:0] oprd3_q;
    logic [63:0] rip_q;

    logic is_mul, is_div, is_multi, div_zero, accept;

    // Op classification and the accept handshake.
    always_comb begin
        is_mul    = (dec_op3[3:1] == 3'b101);
        is_div    = (dec_op3[3:1] == 3'b111);
        is_multi  = (dec_opcode == 2'd2) && (dec_op3[5:4] != 2'b11) && (is_mul || is_div);
        div_zero  = DIV_CHECK && is_multi && is_div && (dec_oprd3 == 32'd0);
        dec_ready = reset_n && !branch &&
                    ((state_q == IDLE) || ((state_q == EXEC) && !mem_blocked));
        accept    = dec_valid && dec_ready;
    end

    // Outputs are masked while reset is asserted so nothing leaks out of a
    // discarded op before the synchronous reset takes effect.
    assign alu_enable   = reset_n && (state_q == EXEC);
    assign busy         = reset_n && (state_q != IDLE);
    assign div_fault    = div_fault_q;
    assign alu_opcode   = opcode_q;
    assign alu_op3      = op3_q;
    assign alu_oprd2    = oprd2_q;
    assign alu_oprd3    = oprd3_q;
    assign alu_next_rip = rip_q;

    // Issue FSM: flush has priority over accept, countdown and mem stall.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            div_fault_q <= 1'b0;
            opcode_q    <= '0;
            op3_q       <= '0;
            oprd2_q     <= '0;
            oprd3_q     <= '0;
            rip_q       <= '0;
        end else begin
            div_fault_q <= 1'b0;
            if (branch) begin
                state_q <= IDLE;
                cnt_q   <= 4'd0;
            end else begin
                case (state_q)
                    WAIT: begin
                        if (cnt_q == 4'd0) state_q <= EXEC;
                        else               cnt_q   <= cnt_q - 4'd1;
                    end
                    EXEC: begin
                        if (!mem_blocked && !accept) state_q <= IDLE;
                    end
                    default: ;
                endcase
                // Accept can only happen from IDLE or an unblocked EXEC, so
                // this overrides the EXEC->IDLE decision above.
                if (accept) begin
                    opcode_q <= dec_opcode;
                    op3_q    <= dec_op3;
                    oprd2_q  <= dec_oprd2;
                    oprd3_q  <= dec_oprd3;
                    rip_q    <= dec_next_rip;
                    if (div_zero) begin
                        state_q     <= IDLE;
                        div_fault_q <= 1'b1;
                    end else if (is_multi) begin
                        state_q <= WAIT;
                        cnt_q   <= is_div ? DIV_LD : MUL_LD;
                    end else begin
                        state_q <= EXEC;
                    end
                end
            end
        end
    end

endmodule
